// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage.
package if_pkg;
    localparam int PC_W = 32;
    localparam int INST_W = 32;
    localparam int PC_INC = 4;
    typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_e;
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: memory request bus, redirect/halt controls and decode handshake of the fetch stage.
interface if_fetch_if #(
    parameter int ADSize = 16,
    parameter int DASize = 32,
    parameter int PCSize = 32
);
    logic              IM_enable;
    logic              IM_write;
    logic [ADSize-1:0] IM_address;
    logic [DASize-1:0] IM_in;
    logic [DASize-1:0] IM_out;
    logic              redirect_valid;
    logic [PCSize-1:0] redirect_pc;
    logic              halt;
    logic              id_valid;
    logic              id_ready;
    logic [DASize-1:0] id_inst;
    logic [PCSize-1:0] id_pc;
    modport master (
        output IM_enable, IM_write, IM_address, IM_in, id_valid, id_inst, id_pc,
        input  IM_out, redirect_valid, redirect_pc, halt, id_ready
    );
    modport slave (
        input  IM_enable, IM_write, IM_address, IM_in, id_valid, id_inst, id_pc,
        output IM_out, redirect_valid, redirect_pc, halt, id_ready
    );
endinterface

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: power-of-two FIFO of fetch entries; flush wins over push and pop.
module if_fetch_buf
    import if_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);
    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC holder issuing one memory read per cycle into a credit-checked buffer feeding decode.
// Define IF_PERF_EN to add saturating handshake/stall counters.
module if_fetch
    import if_pkg::*;
#(
    parameter int          ADSize    = 16,
    parameter int          DASize    = INST_W,
    parameter int          PCSize    = PC_W,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    if_fetch_if.master  bus
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e      state, state_nx;
    logic [PCSize-1:0] pc, req_pc;
    logic              req_v, pop, credit_ok, issue, redirect, id_valid;
    logic [CW:0]       occ;
    logic [CW-1:0]     count;
    fetch_entry_t      head;

    assign redirect = bus.redirect_valid;
    assign id_valid = count != '0;

    // Credit counts the in-flight request so a returning word always has a slot.
    always_comb begin
        state_nx  = (state == BOOT) ? RUN : (bus.halt ? HALTED : RUN);
        pop       = id_valid && bus.id_ready;
        occ       = {1'b0, count} + (CW+1)'(req_v) - (CW+1)'(pop);
        credit_ok = occ < (CW+1)'(BUF_DEPTH);
        issue     = state == RUN && !bus.halt && !redirect && credit_ok;
    end

    always_ff @(posedge clk) begin
        state <= !rst ? BOOT : state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc             <= PCSize'(RESET_PC);
            req_v          <= 1'b0;
            req_pc         <= '0;
            bus.IM_address <= '0;
        end else begin
            req_v <= issue;
            if (issue) begin
                req_pc         <= pc;
                bus.IM_address <= pc[ADSize+1:2];
            end
            pc <= redirect ? {bus.redirect_pc[PCSize-1:2], 2'b00} : issue ? pc + PCSize'(PC_INC) : pc;
        end
    end

    if_fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (req_v),
        .pop   (pop),
        .flush (redirect),
        .din   ('{pc: req_pc, inst: bus.IM_out}),
        .head  (head),
        .count (count)
    );

    assign bus.IM_enable = req_v;
    assign bus.IM_write  = 1'b0;
    assign bus.IM_in     = '0;
    assign bus.id_valid  = id_valid;
    assign bus.id_inst   = id_valid ? head.inst : '0;
    assign bus.id_pc     = id_valid ? head.pc : '0;

`ifdef IF_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (pop && !redirect && !(&perf_fetch_cnt)) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state == RUN && !bus.halt && !redirect && !credit_ok && !(&perf_stall_cnt))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed checks of the fetch stage against a negedge-updating memory preloaded with i+100.
module tb_if_fetch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] mem [65536];

    if_fetch_if b0 ();
    if_fetch_if b1 ();

`ifdef IF_PERF_EN
    logic [31:0] pf0, ps0, pf1, ps1;
    if_fetch u0 (.clk(clk), .rst(rst), .bus(b0), .perf_fetch_cnt(pf0), .perf_stall_cnt(ps0));
    if_fetch #(.RESET_PC(32'h0003_FFFC)) u1 (.clk(clk), .rst(rst), .bus(b1), .perf_fetch_cnt(pf1), .perf_stall_cnt(ps1));
`else
    if_fetch u0 (.clk(clk), .rst(rst), .bus(b0));
    if_fetch #(.RESET_PC(32'h0003_FFFC)) u1 (.clk(clk), .rst(rst), .bus(b1));
`endif

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (b0.IM_enable) b0.IM_out <= mem[b0.IM_address];
        if (b1.IM_enable) b1.IM_out <= mem[b1.IM_address];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        b0.id_ready = 1'b0; b0.halt = 1'b0; b0.redirect_valid = 1'b0; b0.redirect_pc = '0;
        b1.id_ready = 1'b0; b1.halt = 1'b0; b1.redirect_valid = 1'b0; b1.redirect_pc = '0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (b0.IM_enable !== 1'b0) begin errors++; $display("FAIL reset_en: got %b exp 0", b0.IM_enable); end
        checks++; if (b0.IM_address !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0000", b0.IM_address); end
        checks++; if (b0.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", b0.id_valid); end
        checks++; if (b0.id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h exp 0", b0.id_inst); end
        checks++; if (b0.id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", b0.id_pc); end
        checks++; if (b0.IM_write !== 1'b0 || b0.IM_in !== 32'h0) begin errors++; $display("FAIL reset_wr: got %b/%h exp 0/0", b0.IM_write, b0.IM_in); end
        checks++; if (b1.IM_address !== 16'h0) begin errors++; $display("FAIL reset_addr_u1: got %h exp 0000", b1.IM_address); end
    endtask

    task automatic test_stream;
        do_reset;
        b0.id_ready = 1'b1;
        tick;
        checks++; if (b0.IM_enable !== 1'b0) begin errors++; $display("FAIL boot_en: got %b exp 0", b0.IM_enable); end
        tick;
        checks++; if (b0.IM_enable !== 1'b1 || b0.IM_address !== 16'h0) begin errors++; $display("FAIL first_req: got %b/%h exp 1/0000", b0.IM_enable, b0.IM_address); end
        checks++; if (b0.id_valid !== 1'b0) begin errors++; $display("FAIL first_req_valid: got %b exp 0", b0.id_valid); end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'(i * 4) || b0.id_inst !== 32'(100 + i)) begin
                errors++; $display("FAIL stream_%0d: got v=%b pc=%h inst=%0d exp v=1 pc=%h inst=%0d", i, b0.id_valid, b0.id_pc, b0.id_inst, 32'(i * 4), 100 + i);
            end
            checks++; if (b0.IM_write !== 1'b0 || b0.IM_in !== 32'h0) begin errors++; $display("FAIL stream_wr_%0d: got %b/%h exp 0/0", i, b0.IM_write, b0.IM_in); end
        end
    endtask

    task automatic test_stall;
        do_reset;
        tick; tick; tick;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'h0 || b0.id_inst !== 32'd100) begin
                errors++; $display("FAIL stall_hold_%0d: got v=%b pc=%h inst=%0d exp v=1 pc=0 inst=100", i, b0.id_valid, b0.id_pc, b0.id_inst);
            end
            tick;
        end
        checks++; if (b0.IM_enable !== 1'b0) begin errors++; $display("FAIL stall_en: got %b exp 0", b0.IM_enable); end
        b0.id_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick;
            checks++;
            if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'(i * 4) || b0.id_inst !== 32'(100 + i)) begin
                errors++; $display("FAIL stall_resume_%0d: got v=%b pc=%h inst=%0d exp v=1 pc=%h inst=%0d", i, b0.id_valid, b0.id_pc, b0.id_inst, 32'(i * 4), 100 + i);
            end
        end
    endtask

    task automatic test_redirect;
        do_reset;
        tick; tick; tick; tick;
        b0.redirect_valid = 1'b1; b0.redirect_pc = 32'h0000_0102;
        tick;
        b0.redirect_valid = 1'b0;
        checks++; if (b0.id_valid !== 1'b0 || b0.IM_enable !== 1'b0) begin errors++; $display("FAIL redir_flush: got v=%b en=%b exp 0/0", b0.id_valid, b0.IM_enable); end
        tick;
        checks++; if (b0.IM_enable !== 1'b1 || b0.IM_address !== 16'h0040 || b0.id_valid !== 1'b0) begin errors++; $display("FAIL redir_req: got en=%b addr=%h v=%b exp 1/0040/0", b0.IM_enable, b0.IM_address, b0.id_valid); end
        b0.id_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++;
            if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'(32'h100 + i * 4) || b0.id_inst !== 32'(164 + i)) begin
                errors++; $display("FAIL redir_new_%0d: got v=%b pc=%h inst=%0d exp v=1 pc=%h inst=%0d", i, b0.id_valid, b0.id_pc, b0.id_inst, 32'(32'h100 + i * 4), 164 + i);
            end
        end
        do_reset;
        b0.id_ready = 1'b1;
        tick; tick; tick;
        b0.redirect_valid = 1'b1; b0.redirect_pc = 32'h0000_0200;
        tick;
        b0.redirect_valid = 1'b0;
        checks++; if (b0.id_valid !== 1'b0) begin errors++; $display("FAIL squash_v0: got %b exp 0", b0.id_valid); end
        tick;
        checks++; if (b0.id_valid !== 1'b0 || b0.IM_address !== 16'h0080) begin errors++; $display("FAIL squash_v1: got v=%b addr=%h exp 0/0080", b0.id_valid, b0.IM_address); end
        tick;
        checks++; if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'h200 || b0.id_inst !== 32'd228) begin errors++; $display("FAIL squash_new: got v=%b pc=%h inst=%0d exp v=1 pc=200 inst=228", b0.id_valid, b0.id_pc, b0.id_inst); end
    endtask

    task automatic test_halt;
        do_reset;
        b0.id_ready = 1'b1;
        tick; tick; tick;
        b0.halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (b0.IM_enable !== 1'b0) begin errors++; $display("FAIL halt_en_%0d: got %b exp 0", i, b0.IM_enable); end
            if (i == 0) begin
                checks++; if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'h4 || b0.id_inst !== 32'd101) begin errors++; $display("FAIL halt_inflight: got v=%b pc=%h inst=%0d exp v=1 pc=4 inst=101", b0.id_valid, b0.id_pc, b0.id_inst); end
            end else begin
                checks++; if (b0.id_valid !== 1'b0) begin errors++; $display("FAIL halt_empty_%0d: got %b exp 0", i, b0.id_valid); end
            end
        end
        b0.halt = 1'b0;
        tick;
        tick;
        checks++; if (b0.IM_enable !== 1'b1 || b0.IM_address !== 16'h0002) begin errors++; $display("FAIL halt_resume_req: got en=%b addr=%h exp 1/0002", b0.IM_enable, b0.IM_address); end
        for (int i = 2; i < 4; i++) begin
            tick;
            checks++;
            if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'(i * 4) || b0.id_inst !== 32'(100 + i)) begin
                errors++; $display("FAIL halt_resume_%0d: got v=%b pc=%h inst=%0d exp v=1 pc=%h inst=%0d", i, b0.id_valid, b0.id_pc, b0.id_inst, 32'(i * 4), 100 + i);
            end
        end
    endtask

    task automatic test_wrap;
        do_reset;
        b1.id_ready = 1'b1;
        tick; tick;
        checks++; if (b1.IM_enable !== 1'b1 || b1.IM_address !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr0: got en=%b addr=%h exp 1/ffff", b1.IM_enable, b1.IM_address); end
        tick;
        checks++; if (b1.IM_address !== 16'h0000) begin errors++; $display("FAIL wrap_addr1: got %h exp 0000", b1.IM_address); end
        checks++; if (b1.id_valid !== 1'b1 || b1.id_pc !== 32'h0003_FFFC || b1.id_inst !== 32'd65635) begin errors++; $display("FAIL wrap_pc0: got v=%b pc=%h inst=%0d exp v=1 pc=0003fffc inst=65635", b1.id_valid, b1.id_pc, b1.id_inst); end
        tick;
        checks++; if (b1.id_valid !== 1'b1 || b1.id_pc !== 32'h0004_0000 || b1.id_inst !== 32'd100) begin errors++; $display("FAIL wrap_pc1: got v=%b pc=%h inst=%0d exp v=1 pc=00040000 inst=100", b1.id_valid, b1.id_pc, b1.id_inst); end
    endtask

    task automatic test_midreset;
        do_reset;
        b0.id_ready = 1'b1;
        tick; tick; tick;
        checks++; if (b0.id_valid !== 1'b1 || b0.IM_enable !== 1'b1) begin errors++; $display("FAIL midrst_pre: got v=%b en=%b exp 1/1", b0.id_valid, b0.IM_enable); end
        rst = 1'b0;
        b0.redirect_valid = 1'b1; b0.redirect_pc = 32'h0000_0300;
        tick;
        rst = 1'b1;
        b0.redirect_valid = 1'b0;
        checks++; if (b0.id_valid !== 1'b0 || b0.IM_enable !== 1'b0) begin errors++; $display("FAIL midrst_clear: got v=%b en=%b exp 0/0", b0.id_valid, b0.IM_enable); end
        tick;
        checks++; if (b0.IM_enable !== 1'b0 || b0.id_valid !== 1'b0) begin errors++; $display("FAIL midrst_boot: got en=%b v=%b exp 0/0", b0.IM_enable, b0.id_valid); end
        tick;
        checks++; if (b0.IM_enable !== 1'b1 || b0.IM_address !== 16'h0) begin errors++; $display("FAIL midrst_req: got en=%b addr=%h exp 1/0000", b0.IM_enable, b0.IM_address); end
        tick;
        checks++; if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'h0 || b0.id_inst !== 32'd100) begin errors++; $display("FAIL midrst_first: got v=%b pc=%h inst=%0d exp v=1 pc=0 inst=100", b0.id_valid, b0.id_pc, b0.id_inst); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'(i + 100);
        b0.IM_out = '0;
        b1.IM_out = '0;
        test_reset;
        test_stream;
        test_stall;
        test_redirect;
        test_halt;
        test_wrap;
        test_midreset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the 64Kx32 instruction memory.
- Holds the PC and issues one read per cycle to the memory.
- Captures each returned word into a small buffer of (pc, inst) entries.
- Presents the buffer to decode over a valid/ready handshake; supports branch redirect (with flush) and halt.

Parameters:
- ADSize, 16, memory word-address width
- DASize, 32, instruction width
- PCSize, 32, PC width (byte address)
- RESET_PC, 32'h0000_0000, PC loaded at reset
- BUF_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-low reset
- IM_enable  output  1  memory read request
- IM_write  output  1  always 0
- IM_address  output  ADSize  word index, equal to pc[ADSize+1:2]
- IM_in  output  DASize  always 0
- IM_out  input  DASize  read data; memory updates it on negedge
- redirect_valid  input  1  branch/jump redirect
- redirect_pc  input  PCSize  redirect target; bits [1:0] ignored
- halt  input  1  stop issuing new fetches
- id_valid  output  1  buffer head valid
- id_ready  input  1  decode accepts head
- id_inst  output  DASize  head instruction
- id_pc  output  PCSize  head PC

Behaviour:
- Reset (rst==0 at posedge):
  - pc <= RESET_PC; buffer emptied; inflight <= 0; state <= BOOT.
  - IM_enable, IM_address, id_valid, id_inst, id_pc all 0; IM_write and IM_in constant 0.
- Request/response timing:
  - IM_enable and IM_address are registered and driven from posedge of cycle N.
  - Memory samples them at the negedge of N.
  - IM_out is captured at the posedge ending N, so the entry is visible on id_* in cycle N+1.
  - Fetch-to-decode latency is 1 cycle.
- Request record: inflight flag plus the request's pc, registered alongside IM_enable.
- FSM states: BOOT, RUN, HALTED.
  - BOOT: one cycle, no request, then RUN.
  - RUN: issue when !halt and (count + inflight - pop) < BUF_DEPTH, where pop = id_valid && id_ready. On issue, pc <= pc + 4. halt==1 moves to HALTED.
  - HALTED: no new issue; an in-flight response is still captured; returns to RUN when halt==0.
- Throughput: one instruction per cycle sustained when id_ready stays high.
- Buffer: FIFO; head drives id_*.
  - Push on a valid, non-squashed response.
  - Pop on a handshake.
  - Push and pop in the same cycle is allowed and leaves count unchanged.
  - The credit check above guarantees a push is never dropped; there is no overflow path.
- id_inst and id_pc must stay stable while id_valid && !id_ready.
- Redirect (highest priority, any state except reset):
  - Buffer flushed and any pop this cycle is discarded.
  - The in-flight response arriving at the same posedge is squashed.
  - pc <= {redirect_pc[PCSize-1:2], 2'b00}; no request is issued that cycle.
  - First post-redirect request is issued the next cycle, so new-path id_valid appears 2 cycles after the redirect cycle.
  - Redirect while halt==1 still updates pc and flushes.
- Wrap-around: pc increments modulo 2^PCSize; IM_address wraps naturally at 2^ADSize words.
- Mid-operation reset: overrides redirect/halt; the in-flight response is dropped.

Optional Feature:
- Macro: IF_PERF_EN.
- When defined, adds two output ports:
  - perf_fetch_cnt (32): counts accepted handshakes.
  - perf_stall_cnt (32): counts cycles in RUN with no issue due to a full buffer.
  - Both reset to 0 and saturate at all-ones.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package if_pkg:
  - fetch_state_e enum (BOOT, RUN, HALTED)
  - fetch_entry_t struct {pc, inst}
  - constant PC_INC = 4
- One natural sub-module: if_fetch_buf, a parameterised FIFO of fetch_entry_t with push/pop/flush and count output.

Test Plan:
- Reset then id_ready=1, memory preloaded with words[i]=i+100 -> id_pc 0,4,8,... with id_inst 100,101,102 on consecutive cycles from cycle 3 after reset release.
- Hold id_ready=0 for 5 cycles -> id_valid stays 1 with id_pc=0 stable; IM_enable drops once 2 entries are buffered; no instruction is lost on resume.
- redirect_valid with redirect_pc=32'h0000_0102 while 2 entries are buffered -> buffer flushed; next id_pc=32'h100 with word 64, two cycles later; the squashed in-flight word never appears.
- halt=1 for 4 cycles mid-stream -> no new IM_enable pulses; at most one in-flight word is buffered; stream resumes in order after halt=0.
- RESET_PC=32'h0003_FFFC -> IM_address 16'hFFFF then 16'h0000; id_pc 32'h0003_FFFC then 32'h0004_0000.
- rst=0 asserted while id_valid=1 with a request in flight -> next cycle id_valid=0, IM_enable=0; restart from RESET_PC.
